neuron_config_loader: RTL and testbench
=======================================

Name: neuron_config_loader

Overview:
- Writer side of the neuron core configuration memory.
- Accepts a stream of 32-bit configuration words from the router/host interface. Each burst is a header word followed by payload words.
- Drives a one-hot per-memory write enable, a write address and write data into the configuration memory.
- Sits between the NoC local-port deserializer and the configuration memory. It is the only source of config writes.

Parameters:
- DSIZE, 16, datapath half-width; config word is DSIZE*2 bits.
- NURN_CNT_BIT_WIDTH, 8, neuron index width.
- AXON_CNT_BIT_WIDTH, 8, axon index width.
- CONFIG_PARAMETER_NUMBER, 9, number of target memories (one write-enable bit each).
- CNT_BIT_WIDTH, 12, header burst-length field width.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  reset, asynchronous, active-low.
- cfg_word_i  input  DSIZE*2  incoming header/payload word.
- cfg_valid_i  input  1  cfg_word_i valid.
- cfg_ready_o  output  1  loader accepts word this cycle.
- config_data_o  output  DSIZE*2  write data.
- config_write_enable_o  output  CONFIG_PARAMETER_NUMBER  one-hot write strobe.
- config_addr_o  output  NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH  write address.
- ce_o  output  1  memory clock enable; high whenever a strobe is high.
- busy_o  output  1  burst in progress (state != IDLE).
- done_o  output  1  one-cycle pulse at end of burst.
- err_o  output  1  sticky error flag.
- err_clr_i  input  1  synchronous clear of err_o.

Behaviour:
- Handshake:
  - A word transfers when cfg_valid_i && cfg_ready_o.
  - cfg_ready_o = 1 in IDLE, DATA and DRAIN; 0 otherwise. The memory never back-pressures.
- Header word fields:
  - [31:28] target index T.
  - [27:12] start address; the low NURN+AXON bits are used and the upper bits are ignored.
  - [11:0] len-1, so a burst is 1..4096 payload words.
- States:
  - IDLE → DATA on header accept when T < CONFIG_PARAMETER_NUMBER. Load addr counter = start and remaining = len-1.
  - IDLE → DRAIN on header accept when T >= CONFIG_PARAMETER_NUMBER. Set err_o.
  - DATA: each accepted word is registered. Next cycle: config_write_enable_o[T]=1, config_addr_o = current addr, config_data_o = word, ce_o = 1. Then addr increments and remaining decrements.
  - DATA exit: when the last word (remaining == 0) is accepted, go to IDLE, or to CHECK with the option.
  - DRAIN: consume len words with no strobes, then go to IDLE (or CHECK).
- Latency: payload accept in cycle N → strobe in cycle N+1. Back-to-back valid yields one write per cycle.
- done_o pulses in the cycle the final strobe is driven. For a drained burst, it pulses the cycle after the last accept.
- Address wraps modulo 2^(NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH); the wrap is silent and sets no error.
- A new header may be accepted in the cycle right after the last payload word is accepted, while that word's strobe is still being driven.
- cfg_valid_i low mid-burst: the loader stalls and holds all counters. No timeout.
- err_clr_i and a new error in the same cycle: the error wins.
- Reset values:
  - config_write_enable_o=0, ce_o=0, config_data_o=0, config_addr_o=0.
  - done_o=0, err_o=0, busy_o=0, cfg_ready_o=0 during reset.
  - State = IDLE.
- Reset mid-burst aborts immediately. Words already written stay written; no partial strobe is issued.

Optional Feature:
- Macro: CONFIG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last payload (DATA or DRAIN), enter CHECK with cfg_ready_o=1.
  - Accept one extra word and compare it with the running sum mod 2^32 of the header plus all payload words.
  - Mismatch sets err_o. Prior writes are not reverted.
  - done_o pulses on checksum accept.
- Undefined: no CHECK state and no extra word.

Decomposition:
- Shared package/define file holds:
  - header field offsets (TARGET_MSB/LSB, ADDR_MSB/LSB, LEN_MSB/LSB);
  - the state encoding;
  - the target indices that match the config memory enable order.
- Sub-module config_hdr_decode: combinational header split plus target-range check.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- Header T=2, addr 0x0010, len-1=2, then 3 words A,B,C back-to-back → strobe bit 2 on three consecutive cycles. Addresses 0x10, 0x11, 0x12 with data A, B, C. done_o pulses with the third strobe.
- Header addr 0xFFFF, len-1=1, words X,Y → writes at 0xFFFF then 0x0000; err_o stays 0.
- Header T=12 (invalid), len-1=3, 4 words → no strobes, err_o=1 after the header. Back to IDLE after 4 accepts. err_clr_i clears err_o.
- Valid deasserted for 5 cycles between words 1 and 2 → no strobe in the gap; address continues at start+1.
- Assert rst_n_i low after 2 of 5 words → all outputs 0 asynchronously. A following fresh header is processed normally.
- With CONFIG_LOADER_CHECKSUM_EN: 2-word burst plus a correct sum → err_o=0, done_o pulses. Same burst with sum+1 → err_o=1.

Source files
------------

// File: rtl/neuron_config_loader_pkg.sv
// ---------------------------------------------------------------------------
// neuron_config_loader_pkg
// Shared definitions for the neuron core configuration loader:
//   - header word field positions (target / start address / length-1)
//   - loader state encoding
//   - target memory indices, in the same order as the config memory
//     write-enable vector
// Optional feature macro: CONFIG_LOADER_CHECKSUM_EN (adds the CHECK state).
// ---------------------------------------------------------------------------
package neuron_config_loader_pkg;

    localparam int unsigned HDR_W      = 32;

    localparam int unsigned TARGET_MSB = 31;
    localparam int unsigned TARGET_LSB = 28;
    localparam int unsigned ADDR_MSB   = 27;
    localparam int unsigned ADDR_LSB   = 12;
    localparam int unsigned LEN_MSB    = 11;
    localparam int unsigned LEN_LSB    = 0;

    localparam int unsigned TARGET_W   = TARGET_MSB - TARGET_LSB + 1;
    localparam int unsigned ADDR_FLD_W = ADDR_MSB - ADDR_LSB + 1;
    localparam int unsigned LEN_W      = LEN_MSB - LEN_LSB + 1;

    // state | meaning
    // IDLE  | waiting for a header word
    // DATA  | writing payload words into the selected memory
    // DRAIN | swallowing payload of a header with an invalid target
    // CHECK | waiting for the trailing checksum word (checksum build only)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_DRAIN = 2'd2
`ifdef CONFIG_LOADER_CHECKSUM_EN
        ,
        ST_CHECK = 2'd3
`endif
    } state_t;

    // Bit position of each memory in config_write_enable_o.
    typedef enum logic [TARGET_W-1:0] {
        TGT_MEM0 = 4'd0,
        TGT_MEM1 = 4'd1,
        TGT_MEM2 = 4'd2,
        TGT_MEM3 = 4'd3,
        TGT_MEM4 = 4'd4,
        TGT_MEM5 = 4'd5,
        TGT_MEM6 = 4'd6,
        TGT_MEM7 = 4'd7,
        TGT_MEM8 = 4'd8
    } target_e;

    localparam int unsigned TGT_COUNT = 9;

endpackage

// File: rtl/config_hdr_decode.sv
// ---------------------------------------------------------------------------
// config_hdr_decode
// Combinational split of a configuration header word plus target range check.
// Ports:
//   i_word        header word
//   o_target      target memory index T
//   o_addr        start address (low ADDR_W bits of the address field)
//   o_len_m1      burst length minus one
//   o_target_ok   T addresses an existing memory
// ---------------------------------------------------------------------------
module config_hdr_decode
    import neuron_config_loader_pkg::*;
#(
    parameter int unsigned ADDR_W                  = 16,
    parameter int unsigned CONFIG_PARAMETER_NUMBER = TGT_COUNT
) (
    input  logic [HDR_W-1:0]    i_word,
    output logic [TARGET_W-1:0] o_target,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [LEN_W-1:0]    o_len_m1,
    output logic                o_target_ok
);

    logic [ADDR_FLD_W-1:0] w_addr_fld;

    assign o_target    = i_word[TARGET_MSB:TARGET_LSB];
    assign w_addr_fld  = i_word[ADDR_MSB:ADDR_LSB];
    // Upper address-field bits beyond the memory address width are dropped.
    assign o_addr      = ADDR_W'(w_addr_fld);
    assign o_len_m1    = i_word[LEN_MSB:LEN_LSB];
    assign o_target_ok = (32'(o_target) < CONFIG_PARAMETER_NUMBER);

endmodule

// File: rtl/neuron_config_loader.sv
// ---------------------------------------------------------------------------
// neuron_config_loader
// Writer side of the neuron core configuration memory. Takes header+payload
// bursts from the NoC local port and turns each payload word into one
// registered write strobe into the selected config memory.
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   cfg_word_i/valid/ready  incoming word stream (transfer on valid&&ready)
//   config_data_o           write data
//   config_write_enable_o   one-hot write strobe, bit T
//   config_addr_o           write address
//   ce_o                    memory clock enable (high with any strobe)
//   busy_o                  burst in progress
//   done_o                  one-cycle end-of-burst pulse
//   err_o / err_clr_i       sticky error flag and its synchronous clear
// Optional feature macro: CONFIG_LOADER_CHECKSUM_EN -- a trailing word after
// every burst must equal the mod-2^32 sum of header and payload words.
// ---------------------------------------------------------------------------
module neuron_config_loader
    import neuron_config_loader_pkg::*;
#(
    parameter int unsigned DSIZE                   = 16,
    parameter int unsigned NURN_CNT_BIT_WIDTH      = 8,
    parameter int unsigned AXON_CNT_BIT_WIDTH      = 8,
    parameter int unsigned CONFIG_PARAMETER_NUMBER = 9,
    parameter int unsigned CNT_BIT_WIDTH           = 12
) (
    input  logic                                             clk_i,
    input  logic                                             rst_n_i,
    input  logic [DSIZE*2-1:0]                               cfg_word_i,
    input  logic                                             cfg_valid_i,
    output logic                                             cfg_ready_o,
    output logic [DSIZE*2-1:0]                               config_data_o,
    output logic [CONFIG_PARAMETER_NUMBER-1:0]               config_write_enable_o,
    output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] config_addr_o,
    output logic                                             ce_o,
    output logic                                             busy_o,
    output logic                                             done_o,
    output logic                                             err_o,
    input  logic                                             err_clr_i
);

    localparam int unsigned ADDR_W = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
    localparam int unsigned WORD_W = DSIZE * 2;

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic                               r_live;
    logic [TARGET_W-1:0]                r_target;
    logic [ADDR_W-1:0]                  r_addr_cnt;
    logic [CNT_BIT_WIDTH-1:0]           r_remain;
    logic [CONFIG_PARAMETER_NUMBER-1:0] r_we;
    logic [ADDR_W-1:0]                  r_addr;
    logic [WORD_W-1:0]                  r_data;
    logic                               r_ce;
    logic                               r_done;
    logic                               r_err;

    logic                               w_ready_state;
    logic                               w_accept;
    logic                               w_last;
    logic                               w_err_set;
    logic [CONFIG_PARAMETER_NUMBER-1:0] w_strobe;

    logic [TARGET_W-1:0]                w_hdr_target;
    logic [ADDR_W-1:0]                  w_hdr_addr;
    logic [LEN_W-1:0]                   w_hdr_len_m1;
    logic                               w_hdr_ok;

`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]                  r_sum;
`endif

    config_hdr_decode #(
        .ADDR_W                  (ADDR_W),
        .CONFIG_PARAMETER_NUMBER (CONFIG_PARAMETER_NUMBER)
    ) u_hdr_decode (
        .i_word      (cfg_word_i),
        .o_target    (w_hdr_target),
        .o_addr      (w_hdr_addr),
        .o_len_m1    (w_hdr_len_m1),
        .o_target_ok (w_hdr_ok)
    );

`ifdef CONFIG_LOADER_CHECKSUM_EN
    assign w_ready_state = (r_state == ST_IDLE) || (r_state == ST_DATA) ||
                           (r_state == ST_DRAIN) || (r_state == ST_CHECK);
`else
    assign w_ready_state = (r_state == ST_IDLE) || (r_state == ST_DATA) ||
                           (r_state == ST_DRAIN);
`endif

    // r_live keeps ready low while reset is asserted even though the state
    // register already sits in IDLE.
    assign cfg_ready_o = r_live && w_ready_state;
    assign w_accept    = cfg_valid_i && cfg_ready_o;
    assign w_last      = (r_remain == '0);
    assign w_strobe    = CONFIG_PARAMETER_NUMBER'(1) << r_target;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_hdr_ok) begin
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                        w_err_set   = 1'b1;
                    end
                end
            end
            ST_DATA, ST_DRAIN: begin
                if (w_accept && w_last) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    w_state_nxt = ST_CHECK;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_accept) begin
                    w_state_nxt = ST_IDLE;
                    w_err_set   = (cfg_word_i != r_sum);
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_live     <= 1'b0;
            r_target   <= '0;
            r_addr_cnt <= '0;
            r_remain   <= '0;
            r_we       <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_ce       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_we   <= '0;
            r_ce   <= 1'b0;
            r_done <= 1'b0;

            // A new error in the same cycle as a clear request wins.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end

            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        r_target   <= w_hdr_target;
                        r_addr_cnt <= w_hdr_addr;
                        r_remain   <= CNT_BIT_WIDTH'(w_hdr_len_m1);
                    end
                    ST_DATA: begin
                        r_we       <= w_strobe;
                        r_ce       <= 1'b1;
                        r_addr     <= r_addr_cnt;
                        r_data     <= cfg_word_i;
                        r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
                        r_remain   <= r_remain - CNT_BIT_WIDTH'(1);
`ifndef CONFIG_LOADER_CHECKSUM_EN
                        r_done     <= w_last;
`endif
                    end
                    ST_DRAIN: begin
                        r_remain   <= r_remain - CNT_BIT_WIDTH'(1);
`ifndef CONFIG_LOADER_CHECKSUM_EN
                        r_done     <= w_last;
`endif
                    end
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    ST_CHECK: begin
                        r_done     <= 1'b1;
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef CONFIG_LOADER_CHECKSUM_EN
    // Running sum of header and payload words, compared in CHECK.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sum <= '0;
        end else if (w_accept) begin
            if (r_state == ST_IDLE) begin
                r_sum <= cfg_word_i;
            end else if ((r_state == ST_DATA) || (r_state == ST_DRAIN)) begin
                r_sum <= r_sum + cfg_word_i;
            end
        end
    end
`endif

    assign config_write_enable_o = r_we;
    assign config_addr_o         = r_addr;
    assign config_data_o         = r_data;
    assign ce_o                  = r_ce;
    assign done_o                = r_done;
    assign err_o                 = r_err;
    assign busy_o                = (r_state != ST_IDLE);

endmodule

// File: tb/tb_neuron_config_loader.sv
// ---------------------------------------------------------------------------
// tb_neuron_config_loader
// Self-checking bench for neuron_config_loader. A burst-level model turns
// each (target, start, length, payload) burst into the list of memory writes
// it must produce; a monitor collects the writes the DUT actually strobes.
// Builds with or without CONFIG_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_neuron_config_loader;

    localparam int NMEM = 9;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk_i       = 1'b0;
    logic        rst_n_i     = 1'b0;
    logic [31:0] cfg_word_i  = '0;
    logic        cfg_valid_i = 1'b0;
    logic        err_clr_i   = 1'b0;
    logic        cfg_ready_o;
    logic [31:0] config_data_o;
    logic [8:0]  config_write_enable_o;
    logic [15:0] config_addr_o;
    logic        ce_o, busy_o, done_o, err_o;

    neuron_config_loader dut (
        .clk_i                 (clk_i),
        .rst_n_i               (rst_n_i),
        .cfg_word_i            (cfg_word_i),
        .cfg_valid_i           (cfg_valid_i),
        .cfg_ready_o           (cfg_ready_o),
        .config_data_o         (config_data_o),
        .config_write_enable_o (config_write_enable_o),
        .config_addr_o         (config_addr_o),
        .ce_o                  (ce_o),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .err_o                 (err_o),
        .err_clr_i             (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [8:0]  we;
        logic [15:0] addr;
        logic [31:0] data;
        logic        done;
        int          cyc;
    } wr_t;

    typedef struct packed {
        logic [3:0]  t;
        logic [15:0] a;
        logic [11:0] lm1;
        int          n;
        logic [15:0] last_a;
        logic        err;
    } tv_t;

    wr_t mon_q[$];
    wr_t exp_q[$];
    int  cyc      = 0;
    int  done_cnt = 0;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  acc_cyc  = 0;
    logic exp_err = 1'b0;

    // current burst, for the model
    logic [3:0]  g_t;
    logic [15:0] g_a;
    logic [11:0] g_lm1;
    int          g_idx;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [31:0] g_sum;
`endif

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            n_checks++;
            if (ce_o !== (|config_write_enable_o)) begin
                n_fail++;
                $display("FAIL ce_track: ce_o=%0b, required %0b", ce_o, |config_write_enable_o);
            end
            if (done_o) done_cnt++;
            if (config_write_enable_o != '0)
                mon_q.push_back('{we: config_write_enable_o, addr: config_addr_o,
                                  data: config_data_o, done: done_o, cyc: cyc});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the word transfers.
    task automatic send(input logic [31:0] w);
        bit got;
        got = 1'b0;
        cfg_word_i  = w;
        cfg_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (cfg_ready_o) begin
                @(posedge clk_i);
                #1;
                acc_cyc = cyc;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: word 0x%0h not accepted within 20 cycles", w);
        end
    endtask

    task automatic idle();
        cfg_valid_i = 1'b0;
    endtask

    task automatic settle();
        idle();
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic clr_err();
        idle();
        err_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        err_clr_i = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic hdr(input logic [3:0] t, input logic [15:0] a, input logic [11:0] lm1);
        logic [31:0] h;
        h = {t, a, lm1};
        g_t = t; g_a = a; g_lm1 = lm1; g_idx = 0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        g_sum = h;
`endif
        send(h);
        if (int'(t) >= NMEM) exp_err = 1'b1;
    endtask

    task automatic pay();
        logic [31:0] w;
        wr_t e;
        w = $urandom;
        send(w);
        if (int'(g_t) < NMEM) begin
            e.we   = 9'(1) << g_t;
            e.addr = g_a + 16'(g_idx);
            e.data = w;
            e.done = (g_idx == int'(g_lm1)) && !CHK;
            e.cyc  = 0;
            exp_q.push_back(e);
        end
        g_idx++;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        g_sum = g_sum + w;
`endif
    endtask

    task automatic tail();
`ifdef CONFIG_LOADER_CHECKSUM_EN
        send(g_sum);
`endif
    endtask

    task automatic run_burst(input logic [3:0] t, input logic [15:0] a,
                             input logic [11:0] lm1, input int gap_max);
        hdr(t, a, lm1);
        for (int i = 0; i <= int'(lm1); i++) begin
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(0, gap_max);
                if (g > 0) begin
                    idle();
                    repeat (g) @(posedge clk_i);
                    #1;
                end
            end
            pay();
        end
        tail();
    endtask

    task automatic check_model(input string tag);
        wr_t m, e;
        chk({tag, "_nwrites"}, 64'(mon_q.size()), 64'(exp_q.size()));
        while (mon_q.size() > 0 && exp_q.size() > 0) begin
            m = mon_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_we"},   64'(m.we),   64'(e.we));
            chk({tag, "_addr"}, 64'(m.addr), 64'(e.addr));
            chk({tag, "_data"}, 64'(m.data), 64'(e.data));
            chk({tag, "_done"}, 64'(m.done), 64'(e.done));
        end
        mon_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    tv_t tv [7];
    int  d0, nb;

    initial begin
        //        T      start       len-1   n  last addr  err
        tv[0] = '{4'd2,  16'h0010, 12'd2, 3, 16'h0012, 1'b0};
        tv[1] = '{4'd0,  16'hFFFF, 12'd1, 2, 16'h0000, 1'b0};
        tv[2] = '{4'd12, 16'h0100, 12'd3, 0, 16'h0000, 1'b1};
        tv[3] = '{4'd8,  16'h1234, 12'd0, 1, 16'h1234, 1'b0};
        tv[4] = '{4'd9,  16'h0000, 12'd0, 0, 16'h0000, 1'b1};
        tv[5] = '{4'd5,  16'hFFFE, 12'd4, 5, 16'h0002, 1'b0};
        tv[6] = '{4'd15, 16'hABCD, 12'd2, 0, 16'h0000, 1'b1};

        // reset state
        @(negedge clk_i);
        chk("reset_outputs",
            64'({config_write_enable_o, ce_o, config_data_o, config_addr_o,
                 done_o, err_o, busy_o, cfg_ready_o}), 64'(0));
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("ready_after_reset", 64'(cfg_ready_o), 64'(1));
        chk("idle_not_busy", 64'(busy_o), 64'(0));
        @(posedge clk_i);
        #1;

        // table-driven bursts
        for (int k = 0; k < 7; k++) begin
            clr_err();
            d0 = done_cnt;
            run_burst(tv[k].t, tv[k].a, tv[k].lm1, 0);
            settle();
            chk("tv_nwrites", 64'(mon_q.size()), 64'(tv[k].n));
            if (mon_q.size() > 0)
                chk("tv_last_addr", 64'(mon_q[mon_q.size()-1].addr), 64'(tv[k].last_a));
            chk("tv_err", 64'(err_o), 64'(tv[k].err));
            chk("tv_err_model", 64'(err_o), 64'(exp_err));
            chk("tv_done_count", 64'(done_cnt - d0), 64'(1));
            chk("tv_busy", 64'(busy_o), 64'(0));
            check_model("tv");
        end

        // back-to-back: one write per cycle, strobe the cycle after accept
        clr_err();
        run_burst(4'd2, 16'h0010, 12'd2, 0);
        settle();
        chk("b2b_count", 64'(mon_q.size()), 64'(3));
        if (mon_q.size() >= 3) begin
            chk("b2b_consec_1", 64'(mon_q[1].cyc - mon_q[0].cyc), 64'(1));
            chk("b2b_consec_2", 64'(mon_q[2].cyc - mon_q[1].cyc), 64'(1));
            if (!CHK) chk("b2b_latency", 64'(mon_q[2].cyc), 64'(acc_cyc));
        end
        check_model("b2b");

        // invalid target: error right after the header, drain, then clear
        clr_err();
        d0 = done_cnt;
        hdr(4'd12, 16'h0100, 12'd3);
        idle();
        @(negedge clk_i);
        chk("inv_err_after_hdr", 64'(err_o), 64'(1));
        chk("inv_busy", 64'(busy_o), 64'(1));
        @(posedge clk_i);
        #1;
        repeat (4) pay();
        tail();
        idle();
        @(negedge clk_i);
        chk("inv_done_pulse", 64'(done_o), 64'(1));
        chk("inv_back_idle", 64'(busy_o), 64'(0));
        chk("inv_no_strobes", 64'(mon_q.size()), 64'(0));
        @(posedge clk_i);
        #1;
        // clear and new error in the same cycle: error wins
        err_clr_i = 1'b1;
        hdr(4'd15, 16'h0000, 12'd0);
        err_clr_i = 1'b0;
        idle();
        @(negedge clk_i);
        chk("err_wins_over_clr", 64'(err_o), 64'(1));
        @(posedge clk_i);
        #1;
        pay();
        tail();
        clr_err();
        @(negedge clk_i);
        chk("err_cleared", 64'(err_o), 64'(0));
        @(posedge clk_i);
        #1;
        check_model("inv");

        // valid gap of 5 cycles after the first word
        hdr(4'd4, 16'h0040, 12'd2);
        pay();
        idle();
        repeat (5) @(posedge clk_i);
        #1;
        chk("gap_no_strobe", 64'(mon_q.size()), 64'(1));
        chk("gap_still_busy", 64'(busy_o), 64'(1));
        pay();
        pay();
        tail();
        settle();
        if (mon_q.size() >= 2) chk("gap_second_addr", 64'(mon_q[1].addr), 64'(16'h0041));
        check_model("gap");

        // reset in the middle of a burst
        clr_err();
        d0 = done_cnt;
        hdr(4'd3, 16'h0200, 12'd4);
        pay();
        pay();
        idle();
        @(negedge clk_i);
        #1;
        rst_n_i = 1'b0;
        #1;
        chk("rst_mid_outputs",
            64'({config_write_enable_o, ce_o, config_data_o, config_addr_o,
                 done_o, err_o, busy_o, cfg_ready_o}), 64'(0));
        exp_err = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        run_burst(4'd1, 16'h0300, 12'd1, 0);
        settle();
        chk("rst_done_count", 64'(done_cnt - d0), 64'(1));
        check_model("rst");

`ifdef CONFIG_LOADER_CHECKSUM_EN
        clr_err();
        d0 = done_cnt;
        run_burst(4'd2, 16'h0500, 12'd1, 0);
        settle();
        chk("cks_good_err", 64'(err_o), 64'(0));
        chk("cks_good_done", 64'(done_cnt - d0), 64'(1));
        check_model("cks_good");
        hdr(4'd2, 16'h0600, 12'd1);
        pay();
        pay();
        send(g_sum + 32'd1);
        settle();
        chk("cks_bad_err", 64'(err_o), 64'(1));
        check_model("cks_bad");
        clr_err();
`endif

        // randomized bursts against the model
        d0 = done_cnt;
        nb = 0;
        for (int r = 0; r < 40; r++) begin
            logic [3:0]  t;
            logic [11:0] lm1;
            t   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            lm1 = ($urandom_range(0, 5) == 0) ? 12'($urandom_range(8, 40)) : 12'($urandom_range(0, 7));
            run_burst(t, 16'($urandom), lm1, 3 * $urandom_range(0, 1));
            nb++;
            if ($urandom_range(0, 1) == 1) begin
                idle();
                @(negedge clk_i);
                chk("rand_err", 64'(err_o), 64'(exp_err));
                @(posedge clk_i);
                #1;
                if ($urandom_range(0, 2) == 0) clr_err();
            end
        end
        settle();
        chk("rand_done_count", 64'(done_cnt - d0), 64'(nb));
        chk("rand_err_final", 64'(err_o), 64'(exp_err));
        check_model("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
